// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: requester handshakes and register_file write-port signals of the write-back arbiter
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ADDR_W-1:0]  req_rd_add;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       rf_hold;
    logic [ADDR_W-1:0]          rd_add;
    logic [DATA_W-1:0]          data;
    logic                       wen;
    logic                       register_file_enable;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                       init_done;

    modport slave (
        input  req_valid, req_rd_add, req_data, rf_hold,
        output req_ready, rd_add, data, wen, register_file_enable, grant_id, init_done
    );

    modport master (
        output req_valid, req_rd_add, req_data, rf_hold,
        input  req_ready, rd_add, data, wen, register_file_enable, grant_id, init_done
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter for the register_file write port; RF_WB_INIT_EN adds a post-reset x1..x31 zero sweep
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input logic clk,
    input logic rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int GID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {RESET_S, INIT, RUN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GID_W-1:0]   r_rr_ptr;
    logic [GID_W-1:0]   r_grant_id;
    logic [ADDR_W-1:0]  r_rd_add;
    logic [DATA_W-1:0]  r_data;
    logic               r_wen;
    logic               r_rf_en;
    logic               w_found;
    logic [GID_W-1:0]   w_grant;
    logic [NUM_REQ-1:0] w_ready;
    logic [ADDR_W-1:0]  w_sel_add;
    logic [DATA_W-1:0]  w_sel_data;
`ifdef RF_WB_INIT_EN
    logic [ADDR_W-1:0]  r_cnt;
    logic               w_sweep;
`endif

    // scan from rr_ptr downward in priority so the nearest valid requester wins
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_grant = GID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_ready    = (r_state == RUN && !bus.rf_hold && w_found) ? NUM_REQ'(1) << w_grant : '0;
    assign w_sel_add  = bus.req_rd_add[w_grant*ADDR_W +: ADDR_W];
    assign w_sel_data = bus.req_data[w_grant*DATA_W +: DATA_W];
`ifdef RF_WB_INIT_EN
    assign w_sweep    = r_state == INIT && !bus.rf_hold;
`endif

    // next state: leave RESET_S immediately, leave INIT after the last sweep address is issued
    always_comb begin
        w_state_nxt = r_state;
`ifdef RF_WB_INIT_EN
        w_state_nxt = r_state == RESET_S ? INIT : (w_sweep && &r_cnt) ? RUN : r_state;
`else
        w_state_nxt = r_state == RESET_S ? RUN : r_state;
`endif
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= RESET_S;
        else
            r_state <= w_state_nxt;
    end

`ifdef RF_WB_INIT_EN
    // sweep address counter, frozen by rf_hold
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= ADDR_W'(1);
        else if (w_sweep)
            r_cnt <= r_cnt + ADDR_W'(1);
    end
`endif

    // registered write port: accepted request or sweep write, otherwise hold address/data and drop wen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen      <= 1'b0;
            r_rd_add   <= '0;
            r_data     <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_rf_en    <= 1'b0;
        end else begin
            r_rf_en <= 1'b1;
            r_wen   <= 1'b0;
            if (|w_ready) begin
                r_rd_add   <= w_sel_add;
                r_data     <= w_sel_data;
                r_grant_id <= w_grant;
                r_wen      <= |w_sel_add;
                r_rr_ptr   <= GID_W'((int'(w_grant) + 1) % NUM_REQ);
            end
`ifdef RF_WB_INIT_EN
            else if (w_sweep) begin
                r_rd_add <= r_cnt;
                r_data   <= '0;
                r_wen    <= 1'b1;
            end
`endif
        end
    end

    assign bus.req_ready            = w_ready;
    assign bus.rd_add               = r_rd_add;
    assign bus.data                 = r_data;
    assign bus.wen                  = r_wen;
    assign bus.register_file_enable = r_rf_en;
    assign bus.grant_id             = r_grant_id;
    assign bus.init_done            = r_state == RUN;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized and directed checks of the write-back arbiter against a transaction-level model
module tb_regfile_wb_arbiter;
    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int GW = $clog2(N);
`ifdef RF_WB_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();
    regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // register_file stand-in fed from the DUT write port
    logic [DW-1:0] rf [32];
    always @(posedge clk)
        if (bus.register_file_enable && bus.wen)
            rf[bus.rd_add] <= bus.data;

    int tests = 0;
    int fails = 0;

    // model: phase 0=reset 1=sweep 2=run
    int            m_phase, m_cnt, m_rr;
    logic          m_wen, m_rfe;
    logic [AW-1:0] m_add;
    logic [DW-1:0] m_data;
    logic [GW-1:0] m_gid;
    logic [DW-1:0] m_mem [32];
    bit            refill = 1'b0;
    int            holds  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 1; m_rr = 0;
        m_wen = 1'b0; m_rfe = 1'b0; m_add = '0; m_data = '0; m_gid = '0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i] = 1'b1;
        bus.req_rd_add[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic raise_random(input int pct);
        for (int i = 0; i < N; i++)
            if (!bus.req_valid[i] && $urandom_range(99) < pct)
                set_req(i, AW'($urandom), $urandom);
    endtask

    // one clock: check ready before the edge, advance the model, check registered outputs after
    task automatic step(input logic hold);
        int g;
        logic [N-1:0] er;
        bus.rf_hold = hold;
        #2;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && bus.req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
        er = (m_phase == 2 && !hold && g >= 0) ? N'(1) << g : '0;
        check("req_ready", 64'(bus.req_ready), 64'(er));
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            m_rfe = 1'b1;
            m_wen = 1'b0;
            if (m_phase == 0) begin
                m_phase = INIT_EN ? 1 : 2;
            end else if (m_phase == 1) begin
                if (!hold) begin
                    m_wen = 1'b1; m_add = AW'(m_cnt); m_data = '0; m_mem[m_cnt] = '0;
                    if (m_cnt == 31) m_phase = 2;
                    m_cnt++;
                end
            end else if (er != 0) begin
                m_add  = bus.req_rd_add[g*AW +: AW];
                m_data = bus.req_data[g*DW +: DW];
                m_gid  = GW'(g);
                m_wen  = m_add != 0;
                if (m_add != 0) m_mem[m_add] = m_data;
                m_rr = (g + 1) % N;
                bus.req_valid[g] = 1'b0;
                if (refill) set_req(g, AW'($urandom), $urandom);
            end
        end
        check("wen", 64'(bus.wen), 64'(m_wen));
        check("rd_add", 64'(bus.rd_add), 64'(m_add));
        check("data", 64'(bus.data), 64'(m_data));
        check("grant_id", 64'(bus.grant_id), 64'(m_gid));
        check("rf_enable", 64'(bus.register_file_enable), 64'(m_rfe));
        check("init_done", 64'(bus.init_done), 64'(m_phase == 2));
    endtask

    task automatic wait_run();
        for (int c = 0; c < 100 && m_phase != 2; c++) begin
            step(m_phase == 1 && m_cnt == 10 && holds < 3);
            if (m_phase == 1 && m_cnt == 10 && bus.rf_hold) holds++;
        end
        check("reach_run", 64'(bus.init_done), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i] = '0;
            m_mem[i] = '0;
        end
        bus.req_valid = '0; bus.req_rd_add = '0; bus.req_data = '0; bus.rf_hold = 1'b0;
        model_reset();
        rst = 1'b1;
        repeat (2) step(1'b0);
        rst = 1'b0;
        wait_run();
        step(1'b0);
        check("rf5_after_init", 64'(rf[5]), 64'(0));

        set_req(0, 5'd1, 32'h5);
        repeat (2) step(1'b0);
        set_req(1, 5'd2, 32'ha);
        repeat (3) step(1'b0);
        check("rf1", 64'(rf[1]), 64'h5);
        check("rf2", 64'(rf[2]), 64'ha);

        refill = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, AW'($urandom), $urandom);
        repeat (12) step(1'b0);
        refill = 1'b0;
        for (int c = 0; c < 8 && bus.req_valid != 0; c++) step(1'b0);

        set_req(2, 5'd0, 32'h2);
        repeat (3) step(1'b0);
        check("rf0", 64'(rf[0]), 64'(0));

        set_req(1, 5'd7, 32'h11);
        set_req(3, 5'd8, 32'h22);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        holds = 3;
        wait_run();
        repeat (3) step(1'b0);
        check("rf7", 64'(rf[7]), 64'h11);
        check("rf8", 64'(rf[8]), 64'h22);

        holds = 3;
        for (int c = 0; c < 400; c++) begin
            raise_random(40);
            rst = $urandom_range(199) == 0;
            step($urandom_range(9) == 0);
        end
        rst = 1'b0;
        for (int c = 0; c < 60 && (bus.req_valid != 0 || m_phase != 2); c++) step(1'b0);
        check("drained", 64'(bus.req_valid), 64'(0));
        repeat (2) step(1'b0);
        for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), 64'(rf[i]), 64'(m_mem[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and sequencer for the shared `register_file` write port. It takes up to NUM_REQ write-back requesters (ALU, load unit, CSR/multicore message unit, ...) on valid/ready handshakes and grants one per cycle in round-robin order. It drives the registered `rd_add`/`data`/`wen`/`register_file_enable` inputs of `register_file`. Optionally it runs a post-reset zero-initialisation sweep of x1..x31 before accepting traffic.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester write request
- req_rd_add  in  NUM_REQ*ADDR_W  packed destination addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- rf_hold  in  1  freeze write port; no grant, no sweep progress
- rd_add  out  ADDR_W  to register_file rd_add
- data  out  DATA_W  to register_file data
- wen  out  1  to register_file wen
- register_file_enable  out  1  to register_file enable
- grant_id  out  $clog2(NUM_REQ)  index of the requester whose write is currently on rd_add/data
- init_done  out  1  high once in RUN state

## Operation
- FSM states: RESET_S (held while rst=1), INIT, RUN.
- On rst: go to INIT (macro defined) or RUN (macro undefined). rst=1 at any time, including mid-sweep, restarts from that point.
- INIT: the sweep counter starts at 1.
  - Each cycle with rf_hold=0: issue a write of 0 to the counter address, then increment the counter.
  - After address 31 is issued, go to RUN.
  - req_ready=0 throughout INIT.
- RUN: the arbiter considers requesters in order rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  - It grants the first requester with valid=1: req_ready[g]=1 combinationally, and only when rf_hold=0.
- Acceptance = req_valid[i] && req_ready[i].
  - On acceptance, register rd_add/data/grant_id from requester i.
  - Set wen=1 unless the address is 0. Writes to x0 are accepted (handshake completes) but issued with wen=0.
  - Set rr_ptr to (i+1) mod NUM_REQ.
- No acceptance in a cycle: next-cycle wen=0; rd_add/data/grant_id hold their previous values; rr_ptr unchanged.
- Requesters must hold valid/address/data stable until accepted. The arbiter never drops an accepted request.
- register_file_enable: 0 while rst=1; 1 from the first cycle after reset release onward.
- Reset values: wen=0, rd_add=0, data=0, grant_id=0, register_file_enable=0, init_done=0, req_ready=0, rr_ptr=0, sweep counter=1.

## Timing
- req_ready is combinational from req_valid, rr_ptr, state and rf_hold. There is no combinational path from req_data or req_rd_add.
- Latency: a request accepted at edge N appears on rd_add/data/wen after edge N. The register_file commits it at edge N+1.
- Throughput: one write per cycle, sustained.
- Back-to-back grants to the same requester are possible only when no other requester is valid.
- With all NUM_REQ requesters continuously valid, each is granted exactly once every NUM_REQ cycles. Worst-case wait = NUM_REQ-1 cycles (plus rf_hold cycles).
- rf_hold=1: req_ready=0 and next-cycle wen=0. In INIT the sweep counter holds.
- Init sweep duration: 31 cycles plus rf_hold cycles. init_done rises the cycle after the x31 write is issued.
- Two requesters targeting the same rd in consecutive cycles: both are written in grant order; the later write wins.

## Configuration
- RF_WB_INIT_EN defined: the post-reset INIT sweep is present. Registers x1..x31 read 0 after init_done=1.
- RF_WB_INIT_EN undefined:
  - INIT state and sweep counter are compiled out.
  - FSM enters RUN directly after reset.
  - init_done=1 from the first cycle after reset release.
  - Register contents are whatever `register_file` holds.

## Test plan
- Reset then idle, macro defined: wen pulses for 31 consecutive cycles with rd_add 1..31, data 0, req_ready=0 throughout. Then init_done=1, and reading rs1_add=5 returns 0.
- Single requester 0 writes rd=1, data=0x5. Then requester 1 writes rd=2, data=0xa. A register_file read of rs1=1/rs2=2 then returns 0x5/0xa. Each write appears on wen exactly one cycle after its handshake.
- All 4 requesters continuously valid: grant sequence is 0,1,2,3,0,1,... with grant_id matching one cycle later and no requester skipped.
- Requester 2 writes rd=0, data=0x2: handshake completes, wen stays 0, and rs2_add=0 reads 0.
- rf_hold asserted for 3 cycles mid-INIT, starting at address 10: sweep pauses with wen=0, resumes at address 10, and init_done is delayed by 3 cycles.
- rst pulsed for 1 cycle during RUN while requesters 1 and 3 are valid: outputs return to reset values. With the macro defined the sweep restarts at x1. After that, requester 1 is granted before requester 3 (rr_ptr=0).
